// File: rtl/mlp_param_loader.sv
// Serial-to-parallel parameter loader for the 6-16-3 MLP.
// Words arrive one per valid/ready beat and are collected in shadow storage.
// A full set is copied to the output registers in a single cycle, so the
// datapath never sees a partially loaded network.
module mlp_param_loader #(
    parameter int NBits = 16,
    parameter int D0    = 6,
    parameter int D1    = 16,
    parameter int D2    = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                in_valid_i,
    input  logic [NBits-1:0]                    in_data_i,
    output logic                                in_ready_o,
    output logic [D0-1:0][D1-1:0][NBits-1:0]    w1_o,
    output logic [D1-1:0][NBits-1:0]            b1_o,
    output logic [D1-1:0][D2-1:0][NBits-1:0]    w2_o,
    output logic [D2-1:0][NBits-1:0]            b2_o,
    output logic                                params_valid_o,
    output logic                                busy_o,
    output logic                                done_o
);

    // Stream layout: w1 row-major, then b1, then w2 row-major, then b2.
    localparam int NWords = D0*D1 + D1 + D1*D2 + D2;
    localparam int Cw     = $clog2(NWords);
    localparam int B1Base = D0*D1;
    localparam int W2Base = B1Base + D1;
    localparam int B2Base = W2Base + D1*D2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                              state_r;
    logic [Cw-1:0]                       cnt_r;
    logic                                in_ready_r;
    logic                                busy_r;
    logic                                done_r;
    logic                                params_valid_r;
    logic [NBits-1:0]                    shadow_r [NWords];
    logic [D0-1:0][D1-1:0][NBits-1:0]    w1_r;
    logic [D1-1:0][NBits-1:0]            b1_r;
    logic [D1-1:0][D2-1:0][NBits-1:0]    w2_r;
    logic [D2-1:0][NBits-1:0]            b2_r;
    logic                                shadow_we_s;
    logic                                commit_s;

    // A restart in LOAD wins over a same-cycle beat, so that beat is never stored.
    assign shadow_we_s = (state_r == ST_LOAD) && !start_i && in_valid_i;
    assign commit_s    = (state_r == ST_COMMIT);

    // Load sequencer: state, word counter and registered handshake/status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {Cw{1'b0}};
            in_ready_r     <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            params_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r    <= ST_LOAD;
                        cnt_r      <= {Cw{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (start_i) begin
                        cnt_r <= {Cw{1'b0}};
                    end else if (in_valid_i) begin
                        if (cnt_r == Cw'(NWords - 1)) begin
                            state_r    <= ST_COMMIT;
                            in_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + {{(Cw-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_COMMIT: begin
                    state_r        <= ST_IDLE;
                    cnt_r          <= {Cw{1'b0}};
                    busy_r         <= 1'b0;
                    done_r         <= 1'b1;
                    params_valid_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {Cw{1'b0}};
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Shadow capture of accepted words and atomic copy to the committed set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NWords; k++) begin
                shadow_r[k] <= {NBits{1'b0}};
            end
            w1_r <= {(D0*D1*NBits){1'b0}};
            b1_r <= {(D1*NBits){1'b0}};
            w2_r <= {(D1*D2*NBits){1'b0}};
            b2_r <= {(D2*NBits){1'b0}};
        end else begin
            if (shadow_we_s) begin
                shadow_r[cnt_r] <= in_data_i;
            end
            if (commit_s) begin
                for (int i = 0; i < D0; i++) begin
                    for (int j = 0; j < D1; j++) begin
                        w1_r[i][j] <= shadow_r[i*D1 + j];
                    end
                end
                for (int j = 0; j < D1; j++) begin
                    b1_r[j] <= shadow_r[B1Base + j];
                end
                for (int i = 0; i < D1; i++) begin
                    for (int j = 0; j < D2; j++) begin
                        w2_r[i][j] <= shadow_r[W2Base + i*D2 + j];
                    end
                end
                for (int j = 0; j < D2; j++) begin
                    b2_r[j] <= shadow_r[B2Base + j];
                end
            end
        end
    end

    assign in_ready_o     = in_ready_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign params_valid_o = params_valid_r;
    assign w1_o           = w1_r;
    assign b1_o           = b1_r;
    assign w2_o           = w2_r;
    assign b2_o           = b2_r;

endmodule
